// File: rtl/pipe_pkg.sv
// Shared decode constants and the control bundle for the MIPS ID stage.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_SLTI  = 6'h0a;

  // Control bits that travel to EX alongside the ALU operation.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic regdst;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file; entry 0 is hard-wired to zero and a
// same-cycle write is bypassed to the read ports.
module id_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
)(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wAddr_i,
  input  logic [DATA_W-1:0] wData_i,
  input  logic [AW-1:0]     rsAddr_i,
  input  logic [AW-1:0]     rtAddr_i,
  output logic [DATA_W-1:0] rsData_o,
  output logic [DATA_W-1:0] rtData_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Storage update: writes to entry 0 are dropped so it always reads zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wAddr_i != '0)) begin
      regs_q[wAddr_i] <= wData_i;
    end
  end

  // Read ports with write-through so the writeback value is seen this cycle.
  always_comb begin
    rsData_o = '0;
    rtData_o = '0;
    if (rsAddr_i != '0) begin
      if (we_i && (wAddr_i == rsAddr_i)) rsData_o = wData_i;
      else                               rsData_o = regs_q[rsAddr_i];
    end
    if (rtAddr_i != '0) begin
      if (we_i && (wAddr_i == rtAddr_i)) rtData_o = wData_i;
      else                               rtData_o = regs_q[rtAddr_i];
    end
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: register file, control decode, hazard
// detection, early branch resolution and the registered ID/EX boundary.
module id_stage_pipelined
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ALUOP_W  = 6,
  parameter int CNT_W    = 16,
  localparam int REG_AW  = $clog2(NUM_REGS)
)(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               if_valid,
  input  logic [31:0]        if_instr,
  input  logic [DATA_W-1:0]  if_pc4,
  input  logic               hold,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_memread,
  input  logic               ex_regwrite,
  input  logic [REG_AW-1:0]  ex_dst,
  input  logic               mem_regwrite,
  input  logic [REG_AW-1:0]  mem_dst,
  input  logic [DATA_W-1:0]  mem_result,
  output logic               stall,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  branch_target,
  output logic               idex_valid,
  output logic               idex_regwrite,
  output logic               idex_memtoreg,
  output logic               idex_memread,
  output logic               idex_memwrite,
  output logic               idex_alusrc,
  output logic               idex_regdst,
  output logic [ALUOP_W-1:0] idex_aluop,
  output logic [DATA_W-1:0]  idex_rs_data,
  output logic [DATA_W-1:0]  idex_rt_data,
  output logic [DATA_W-1:0]  idex_imm,
  output logic [REG_AW-1:0]  idex_rs,
  output logic [REG_AW-1:0]  idex_rt,
  output logic [REG_AW-1:0]  idex_rd,
  output logic [DATA_W-1:0]  idex_pc4,
  output logic [CNT_W-1:0]   stall_count
);

  typedef struct packed {
    logic               valid;
    ctrl_t              ctrl;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  rsData;
    logic [DATA_W-1:0]  rtData;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  pc4;
  } idex_t;

  idex_t              idex_q, idex_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               memLoad_q, memLoad_d;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [15:0]        imm16;
  logic [REG_AW-1:0]  rsIdx, rtIdx, rdIdx;
  logic [DATA_W-1:0]  immSext, immZext;
  logic [DATA_W-1:0]  rfRs, rfRt, brA, brB;

  ctrl_t              ctrl;
  logic [ALUOP_W-1:0] aluop;
  logic               usesRs, usesRt, isBeq, isBne, zeroExt;
  logic               isBranch, loadUse, branchHaz, memLoadHaz, operandsEq;

  assign opcode  = if_instr[31:26];
  assign funct   = if_instr[5:0];
  assign imm16   = if_instr[15:0];
  assign rsIdx   = REG_AW'(if_instr[25:21]);
  assign rtIdx   = REG_AW'(if_instr[20:16]);
  assign rdIdx   = REG_AW'(if_instr[15:11]);
  assign immSext = {{(DATA_W-16){imm16[15]}}, imm16};
  assign immZext = {{(DATA_W-16){1'b0}}, imm16};

  id_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i    (Clk),
    .reset_i  (Reset),
    .we_i     (wb_we),
    .wAddr_i  (wb_addr),
    .wData_i  (wb_data),
    .rsAddr_i (rsIdx),
    .rtAddr_i (rtIdx),
    .rsData_o (rfRs),
    .rtData_o (rfRt)
  );

  // Control decode; unknown opcodes fall through as an all-zero NOP.
  always_comb begin
    ctrl    = '0;
    aluop   = '0;
    usesRs  = 1'b0;
    usesRt  = 1'b0;
    isBeq   = 1'b0;
    isBne   = 1'b0;
    zeroExt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        aluop         = ALUOP_W'(funct);
        usesRs        = 1'b1;
        usesRt        = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
        aluop         = ALUOP_W'(opcode);
        usesRs        = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        aluop         = ALUOP_W'(opcode);
        usesRs        = 1'b1;
        usesRt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        isBeq  = (opcode == OP_BEQ);
        isBne  = (opcode == OP_BNE);
        aluop  = ALUOP_W'(opcode);
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        aluop         = ALUOP_W'(opcode);
        usesRs        = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        aluop         = ALUOP_W'(opcode);
        usesRs        = 1'b1;
        zeroExt       = 1'b1;
      end
      default: ;
    endcase
  end

  assign isBranch = isBeq | isBne;

  // A load in EX cannot forward in time for any consumer in ID.
  assign loadUse = if_valid && ex_memread && (ex_dst != '0) &&
                   ((usesRs && (ex_dst == rsIdx)) || (usesRt && (ex_dst == rtIdx)));

  // Branches compare in ID, so any EX producer of an operand must drain first.
  assign branchHaz = if_valid && isBranch && ex_regwrite && (ex_dst != '0) &&
                     ((ex_dst == rsIdx) || (ex_dst == rtIdx));

  // A load sitting in MEM has no data yet, so the branch waits one more cycle.
  assign memLoadHaz = if_valid && isBranch && mem_regwrite && memLoad_q && (mem_dst != '0) &&
                      ((mem_dst == rsIdx) || (mem_dst == rtIdx));

  assign stall = loadUse | branchHaz | memLoadHaz;

  // Branch operands prefer the MEM result over the (older) register file value.
  always_comb begin
    brA = rfRs;
    brB = rfRt;
    if (mem_regwrite && (mem_dst != '0) && (mem_dst == rsIdx)) brA = mem_result;
    if (mem_regwrite && (mem_dst != '0) && (mem_dst == rtIdx)) brB = mem_result;
  end

  assign operandsEq    = (brA == brB);
  assign branch_taken  = if_valid && !stall && !hold &&
                         ((isBeq && operandsEq) || (isBne && !operandsEq));
  assign branch_target = if_pc4 + (immSext << 2);

  // Next ID/EX contents: hold keeps everything, a stall inserts a bubble.
  always_comb begin
    idex_d    = idex_q;
    memLoad_d = ex_memread;
    cnt_d     = cnt_q;
    if (!hold) begin
      if (stall) begin
        idex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        idex_d.valid  = if_valid;
        idex_d.ctrl   = ctrl;
        idex_d.aluop  = aluop;
        idex_d.rsData = rfRs;
        idex_d.rtData = rfRt;
        idex_d.imm    = zeroExt ? immZext : immSext;
        idex_d.rs     = rsIdx;
        idex_d.rt     = rtIdx;
        idex_d.rd     = rdIdx;
        idex_d.pc4    = if_pc4;
      end
    end
  end

  // ID/EX boundary, stall counter and the MEM-is-a-load tag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idex_q    <= '0;
      cnt_q     <= '0;
      memLoad_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      cnt_q     <= cnt_d;
      memLoad_q <= memLoad_d;
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_regwrite = idex_q.ctrl.regwrite;
  assign idex_memtoreg = idex_q.ctrl.memtoreg;
  assign idex_memread  = idex_q.ctrl.memread;
  assign idex_memwrite = idex_q.ctrl.memwrite;
  assign idex_alusrc   = idex_q.ctrl.alusrc;
  assign idex_regdst   = idex_q.ctrl.regdst;
  assign idex_aluop    = idex_q.aluop;
  assign idex_rs_data  = idex_q.rsData;
  assign idex_rt_data  = idex_q.rtData;
  assign idex_imm      = idex_q.imm;
  assign idex_rs       = idex_q.rs;
  assign idex_rt       = idex_q.rt;
  assign idex_rd       = idex_q.rd;
  assign idex_pc4      = idex_q.pc4;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed scenarios then random
// traffic, checked against an instruction-level reference model.
module tb_id_stage_pipelined;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [DW-1:0] if_pc4;
  logic          hold;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_memread, ex_regwrite;
  logic [AW-1:0] ex_dst;
  logic          mem_regwrite;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_result;
  logic          stall, branch_taken;
  logic [DW-1:0] branch_target;
  logic          idex_valid, idex_regwrite, idex_memtoreg, idex_memread;
  logic          idex_memwrite, idex_alusrc, idex_regdst;
  logic [5:0]    idex_aluop;
  logic [DW-1:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc4;
  logic [AW-1:0] idex_rs, idex_rt, idex_rd;
  logic [CW-1:0] stall_count;

  always #5 Clk = ~Clk;

  id_stage_pipelined #(
    .DATA_W(DW), .NUM_REGS(32), .ALUOP_W(6), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc4(if_pc4), .hold(hold), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_dst(ex_dst), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .mem_result(mem_result), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .idex_valid(idex_valid),
    .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_alusrc(idex_alusrc), .idex_regdst(idex_regdst),
    .idex_aluop(idex_aluop), .idex_rs_data(idex_rs_data),
    .idex_rt_data(idex_rt_data), .idex_imm(idex_imm), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_pc4(idex_pc4),
    .stall_count(stall_count)
  );

  typedef struct {
    bit          rst, v, hold, wbWe, exMr, exRw, memRw;
    logic [31:0] instr, pc4, wbD, memRes;
    logic [4:0]  wbA, exDst, memDst;
  } stim_t;

  typedef struct {
    logic        stall, taken;
    logic [31:0] target;
  } combExp_t;

  typedef struct {
    int          due;
    logic        valid, rw, m2r, mr, mw, as, rdst;
    logic [5:0]  aluop;
    logic [31:0] rsD, rtD, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  cnt;
  } regExp_t;

  combExp_t    combQ[$];
  regExp_t     regQ[$];
  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;

  logic [31:0] mRegs [32];
  bit          mMemTag;
  regExp_t     mIdex;
  int          mCnt;

  stim_t       s;

  // Cycle index used to decide when a registered expectation becomes due.
  always @(posedge Clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mRead(input logic [4:0] r, input stim_t t);
    if (r == 5'd0) return 32'd0;
    if (t.wbWe && t.wbA == r) return t.wbD;
    return mRegs[r];
  endfunction

  // Drive one cycle of inputs, predict the response, advance the model.
  task automatic applyStimulus(input stim_t t);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] sext, a, b;
    bit isR, isLw, isSw, isBeq, isBne, isArith, isLogic, known, usesRt, isBr;
    bit ldUse, brHaz, memHaz, stl, taken;
    combExp_t    c;
    regExp_t     r;

    Reset = t.rst; if_valid = t.v; if_instr = t.instr; if_pc4 = t.pc4;
    hold = t.hold; wb_we = t.wbWe; wb_addr = t.wbA; wb_data = t.wbD;
    ex_memread = t.exMr; ex_regwrite = t.exRw; ex_dst = t.exDst;
    mem_regwrite = t.memRw; mem_dst = t.memDst; mem_result = t.memRes;

    op = t.instr[31:26]; rs = t.instr[25:21]; rt = t.instr[20:16];
    sext    = {{16{t.instr[15]}}, t.instr[15:0]};
    isR     = (op == 6'h00);
    isLw    = (op == 6'h23);
    isSw    = (op == 6'h2b);
    isBeq   = (op == 6'h04);
    isBne   = (op == 6'h05);
    isArith = (op == 6'h08) || (op == 6'h0a);
    isLogic = (op == 6'h0c) || (op == 6'h0d);
    known   = isR || isLw || isSw || isBeq || isBne || isArith || isLogic;
    usesRt  = isR || isSw || isBeq || isBne;
    isBr    = isBeq || isBne;

    ldUse  = t.v && t.exMr && t.exDst != 0 && ((known && t.exDst == rs) || (usesRt && t.exDst == rt));
    brHaz  = t.v && isBr && t.exRw && t.exDst != 0 && (t.exDst == rs || t.exDst == rt);
    memHaz = t.v && isBr && t.memRw && mMemTag && t.memDst != 0 && (t.memDst == rs || t.memDst == rt);
    stl    = ldUse || brHaz || memHaz;

    a = (t.memRw && t.memDst != 0 && t.memDst == rs) ? t.memRes : mRead(rs, t);
    b = (t.memRw && t.memDst != 0 && t.memDst == rt) ? t.memRes : mRead(rt, t);
    taken = t.v && !stl && !t.hold && ((isBeq && a == b) || (isBne && a != b));

    c.stall = stl; c.taken = taken; c.target = t.pc4 + sext * 4;
    combQ.push_back(c);

    if (t.rst) begin
      mIdex = '{default: 0};
      mCnt = 0;
    end else if (!t.hold) begin
      if (stl) begin
        mIdex = '{default: 0};
        if (mCnt < (1 << CW) - 1) mCnt++;
      end else begin
        mIdex.valid = t.v;
        mIdex.rw    = isR || isLw || isArith || isLogic;
        mIdex.m2r   = isLw;
        mIdex.mr    = isLw;
        mIdex.mw    = isSw;
        mIdex.as    = isLw || isSw || isArith || isLogic;
        mIdex.rdst  = isR;
        mIdex.aluop = isR ? t.instr[5:0] : (known ? op : 6'd0);
        mIdex.rsD   = mRead(rs, t);
        mIdex.rtD   = mRead(rt, t);
        mIdex.imm   = isLogic ? {16'd0, t.instr[15:0]} : sext;
        mIdex.rs    = rs;
        mIdex.rt    = rt;
        mIdex.rd    = t.instr[15:11];
        mIdex.pc4   = t.pc4;
      end
    end
    mIdex.cnt = 4'(mCnt);

    if (t.rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mMemTag = 1'b0;
    end else begin
      if (t.wbWe && t.wbA != 0) mRegs[t.wbA] = t.wbD;
      mMemTag = t.exMr;
    end

    r = mIdex;
    r.due = cycleCount + 1;
    regQ.push_back(r);
  endtask

  task automatic step(input stim_t t);
    applyStimulus(t);
    @(posedge Clk);
    #1;
  endtask

  function automatic stim_t quiet();
    stim_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic stim_t randStim();
    stim_t t;
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2b; 3: op = 6'h04; 4: op = 6'h05;
      5: op = 6'h08; 6: op = 6'h0c; 7: op = 6'h0d; 8: op = 6'h0a; default: op = 6'h3f;
    endcase
    t.instr  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 6'($urandom)};
    t.rst    = ($urandom_range(0, 49) == 0);
    t.v      = ($urandom_range(0, 7) != 0);
    t.hold   = ($urandom_range(0, 5) == 0);
    t.pc4    = $urandom & 32'hffff_fffc;
    t.wbWe   = $urandom_range(0, 1);
    t.wbA    = 5'($urandom_range(0, 7));
    t.wbD    = $urandom;
    t.exMr   = ($urandom_range(0, 2) == 0);
    t.exRw   = $urandom_range(0, 1);
    t.exDst  = 5'($urandom_range(0, 7));
    t.memRw  = $urandom_range(0, 1);
    t.memDst = 5'($urandom_range(0, 7));
    t.memRes = $urandom;
    return t;
  endfunction

  // Monitor: combinational outputs every cycle, ID/EX once its edge has passed.
  initial begin
    combExp_t c;
    regExp_t  r;
    forever begin
      @(negedge Clk);
      if (combQ.size() > 0) begin
        c = combQ.pop_front();
        checkOutput("stall", stall, c.stall);
        checkOutput("branch_taken", branch_taken, c.taken);
        checkOutput("branch_target", branch_target, c.target);
      end
      while (regQ.size() > 0 && regQ[0].due <= cycleCount) begin
        r = regQ.pop_front();
        checkOutput("idex_valid", idex_valid, r.valid);
        checkOutput("idex_regwrite", idex_regwrite, r.rw);
        checkOutput("idex_memtoreg", idex_memtoreg, r.m2r);
        checkOutput("idex_memread", idex_memread, r.mr);
        checkOutput("idex_memwrite", idex_memwrite, r.mw);
        checkOutput("idex_alusrc", idex_alusrc, r.as);
        checkOutput("idex_regdst", idex_regdst, r.rdst);
        checkOutput("idex_aluop", idex_aluop, r.aluop);
        checkOutput("idex_rs_data", idex_rs_data, r.rsD);
        checkOutput("idex_rt_data", idex_rt_data, r.rtD);
        checkOutput("idex_imm", idex_imm, r.imm);
        checkOutput("idex_rs", idex_rs, r.rs);
        checkOutput("idex_rt", idex_rt, r.rt);
        checkOutput("idex_rd", idex_rd, r.rd);
        checkOutput("idex_pc4", idex_pc4, r.pc4);
        checkOutput("stall_count", stall_count, r.cnt);
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mMemTag = 1'b0;
    mIdex = '{default: 0};
    mCnt = 0;
    s = quiet();
    s.rst = 1;
    Reset = 1'b1; if_valid = 0; if_instr = 0; if_pc4 = 0; hold = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_memread = 0; ex_regwrite = 0;
    ex_dst = 0; mem_regwrite = 0; mem_dst = 0; mem_result = 0;
    repeat (2) @(posedge Clk);
    #1;

    repeat (3) begin
      s = randStim();
      s.rst = 1;
      step(s);
    end
    checkOutput("rst_valid", idex_valid, 0);
    checkOutput("rst_count", stall_count, 0);

    s = quiet(); s.v = 1; s.instr = rType(5, 0, 6);
    step(s);
    checkOutput("reg5_after_rst", idex_rs_data, 0);
    s.wbWe = 1; s.wbA = 5; s.wbD = 32'h1234;
    step(s);
    checkOutput("wb_bypass", idex_rs_data, 32'h1234);
    checkOutput("add_regdst", idex_regdst, 1);
    s = quiet(); s.v = 1; s.instr = rType(0, 0, 6); s.wbWe = 1; s.wbA = 0; s.wbD = 32'hdead;
    step(s);
    checkOutput("reg0_write_bypass", idex_rs_data, 0);
    s.wbWe = 0;
    step(s);
    checkOutput("reg0_write_ignored", idex_rs_data, 0);

    s = quiet(); s.v = 1; s.instr = rType(8, 1, 9); s.exMr = 1; s.exRw = 1; s.exDst = 8;
    step(s);
    checkOutput("loaduse_bubble", idex_valid, 0);
    checkOutput("loaduse_count", stall_count, 1);
    s.exMr = 0; s.exRw = 0;
    step(s);
    checkOutput("loaduse_resume", idex_valid, 1);

    s = quiet(); s.wbWe = 1; s.wbA = 2; s.wbD = 7;
    step(s);
    s.wbA = 3;
    step(s);
    s = quiet(); s.v = 1; s.pc4 = 32'h100; s.instr = iType(6'h04, 2, 3, 16'h0004);
    applyStimulus(s);
    #1;
    checkOutput("beq_taken", branch_taken, 1);
    checkOutput("beq_target", branch_target, 32'h110);
    @(posedge Clk); #1;
    s.instr = iType(6'h04, 2, 3, 16'hfffe); s.memRw = 1; s.memDst = 2; s.memRes = 9;
    applyStimulus(s);
    #1;
    checkOutput("beq_memfwd_taken", branch_taken, 0);
    checkOutput("beq_neg_target", branch_target, 32'h0f8);
    @(posedge Clk); #1;

    s = quiet(); s.v = 1; s.instr = iType(6'h05, 4, 0, 16'h0010); s.exRw = 1; s.exDst = 4;
    step(s);
    s.exRw = 0; s.memRw = 1; s.memDst = 4; s.memRes = 5;
    step(s);
    s = quiet(); s.v = 1; s.instr = iType(6'h05, 4, 0, 16'h0010); s.exMr = 1; s.exRw = 1; s.exDst = 4;
    step(s);
    s.exMr = 0; s.exRw = 0; s.memRw = 1; s.memDst = 4; s.memRes = 5;
    step(s);
    s.memRw = 0; s.wbWe = 1; s.wbA = 4; s.wbD = 5;
    step(s);
    checkOutput("branch_stall_count", stall_count, 4);

    s = quiet(); s.v = 1; s.pc4 = 32'habc0; s.instr = iType(6'h08, 1, 2, 16'h0003);
    step(s);
    s = quiet(); s.v = 1; s.hold = 1; s.instr = rType(8, 1, 9); s.exMr = 1; s.exRw = 1; s.exDst = 8;
    repeat (3) step(s);
    checkOutput("hold_pc4", idex_pc4, 32'habc0);
    checkOutput("hold_valid", idex_valid, 1);
    checkOutput("hold_count", stall_count, 4);
    s.hold = 0;
    repeat (15) step(s);
    checkOutput("count_saturated", stall_count, 15);
    repeat (2) step(s);
    checkOutput("count_stays_saturated", stall_count, 15);

    repeat (3000) step(randStim());

    s = quiet();
    step(s);
    repeat (4) @(posedge Clk);
    checkOutput("scoreboard_drained", combQ.size() + regQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised next-generation instruction-decode stage for the 5-stage MIPS pipeline.
- Merges register file, control decode and sign extension with:
  - a registered ID/EX boundary,
  - load-use and branch hazard detection with bubble insertion,
  - early branch resolution in ID, with forwarding from MEM,
  - an external hold and a saturating stall counter.
- Sits between the IF/ID register and the EX stage.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register-file entries; REG_AW = clog2(NUM_REGS), derived.
- ALUOP_W, 6, width of the ALU operation field.
- CNT_W, 16, stall-counter width.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  32  instruction word.
- if_pc4  in  DATA_W  PC+4 of the instruction.
- hold  in  1  downstream busy; freeze ID/EX.
- wb_we  in  1  writeback enable.
- wb_addr  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_memread  in  1  instruction in EX is a load.
- ex_regwrite  in  1  instruction in EX writes a register.
- ex_dst  in  REG_AW  EX destination.
- mem_regwrite  in  1  MEM writes a register.
- mem_dst  in  REG_AW  MEM destination.
- mem_result  in  DATA_W  MEM ALU result, for branch forwarding.
- stall  out  1  IF and IF/ID must hold this cycle (combinational).
- branch_taken  out  1  redirect PC; upstream flushes IF/ID (combinational).
- branch_target  out  DATA_W  if_pc4 + (sext(imm) << 2).
- idex_valid, idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite, idex_alusrc, idex_regdst  out  1 each  registered control.
- idex_aluop  out  ALUOP_W  registered.
- idex_rs_data, idex_rt_data, idex_imm  out  DATA_W  registered.
- idex_rs, idex_rt, idex_rd  out  REG_AW  registered.
- idex_pc4  out  DATA_W  registered.
- stall_count  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- **Reset (synchronous, active-high)**
  - Clears all registers, every idex_* output and stall_count to 0.
  - Reset mid-operation discards the in-flight instruction.
- **Register file**
  - Entry 0 reads 0 and ignores writes.
  - Write occurs on the edge when wb_we=1 and wb_addr!=0.
  - Reads are combinational with write-through bypass: a same-cycle wb_addr match returns wb_data.
- **Decode** (opcode/funct constants in package)
  - Supported: R-type, addi, andi, ori, slti, lw, sw, beq, bne.
  - R-type: regdst=1, regwrite=1, aluop = funct[ALUOP_W-1:0].
  - Others: aluop = opcode zero-extended/truncated to ALUOP_W.
  - andi and ori zero-extend imm; all others sign-extend.
  - Unknown opcode decodes to all-zero controls, valid passes through (NOP).
- **Operand use**
  - uses_rs is set for all supported instructions.
  - uses_rt is set for R-type, sw, beq, bne.
- **Load-use hazard:** if_valid & ex_memread & ex_dst!=0 & ((uses_rs & ex_dst==rs) | (uses_rt & ex_dst==rt)).
- **Branch hazard:** if_valid & branch & ex_regwrite & ex_dst!=0 & ex_dst matches rs or rt.
- **stall** = load-use hazard | branch hazard.
  - A load feeding a branch therefore stalls 2 cycles: EX, then MEM is a load; MEM loads are not forwarded. Also stall when mem_regwrite & mem_dst matches and the MEM instruction is a load. For this, an internal registered copy of ex_memread delayed one cycle tags MEM.
- **Branch compare**
  - Operands are taken from mem_result when mem_regwrite & mem_dst!=0 & mem_dst matches; otherwise from the register file.
  - branch_taken = if_valid & ~stall & ~hold & (beq ? eq : bne ? ~eq : 0).
- **ID/EX update priority:** Reset > hold (keep all) > stall (bubble) > load.
  - Bubble: valid=0, all control 0, data fields don't-care but driven 0.
  - Load: capture decode; idex_valid = if_valid.
  - Branches load with regwrite=0 and memwrite=0.
- **stall_count** increments on each bubble cycle (stall & ~hold) and saturates at all-ones.
- **hold** asserts stall externally? No: hold only freezes ID/EX. Upstream also freezes IF on hold.
- **Latency:** 1 cycle from IF/ID to idex_*; branch_taken and stall are 0-cycle.

Decomposition:
- Package pipe_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI);
  - the control-bundle struct/width constant.
- Sub-module id_regfile (parametrised DATA_W/NUM_REGS, with bypass).
- Decode, hazard logic and the ID/EX register stay in the top.

Test Plan:
- Reset with random inputs held 3 cycles -> all idex_* = 0, stall_count = 0, reg $5 reads 0.
- wb_we=1 wb_addr=5 wb_data=0x1234 while decoding `add $6,$5,$0` in the same cycle -> next edge idex_rs_data = 0x1234, idex_regdst=1. Write to $0 -> reads 0.
- EX has `lw $8`, ID has `add $9,$8,$1` -> stall=1 one cycle, bubble idex_valid=0, stall_count=1. Next cycle add loads normally.
- `beq $2,$3` with $2=$3=7 in regfile -> branch_taken=1, branch_target = pc4+(imm<<2). With mem_dst=2 and mem_result=9 -> branch_taken=0.
- `bne $4,$0` with ex_regwrite & ex_dst=4 -> 1 stall, then resolves using MEM forward. With EX being `lw $4` -> 2 stall cycles.
- hold=1 during stall for 3 cycles -> idex_* unchanged, stall_count unchanged. stall_count preset near all-ones plus 2 stalls -> stays at all-ones.
